vx_mem_port_splitter: RTL and testbench



---
 rtl/vx_mem_port_splitter.sv | 219 +++++++++++++++++++++
 tb/tb_vx_mem_port_splitter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_port_splitter.sv
// vx_mem_port_splitter
// Splits the single LLC memory-side port into NUM_PORTS address-interleaved
// channels and merges the read responses back into one stream.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_req_*                   upstream request (valid/ready, rw, byteen, addr, data, tag)
//   in_rsp_*                   upstream read response (valid/ready, data, tag)
//   mem_req_*                  per-channel requests, channel i in slice i
//   mem_rsp_*                  per-channel read responses, channel i in slice i
//   perf_reads/writes/latency  wrapping performance counters
//   busy                       a channel has a pending read or a full request register
module vx_mem_port_splitter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 26,
  parameter int DATA_WIDTH     = 512,
  parameter int TAG_WIDTH      = 8,
  parameter int INTERLEAVE_LSB = 0,
  parameter int MAX_PENDING    = 16,
  parameter int CTR_WIDTH      = 44
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_req_valid,
  output logic                                in_req_ready,
  input  logic                                in_req_rw,
  input  logic [DATA_WIDTH/8-1:0]             in_req_byteen,
  input  logic [ADDR_WIDTH-1:0]               in_req_addr,
  input  logic [DATA_WIDTH-1:0]               in_req_data,
  input  logic [TAG_WIDTH-1:0]                in_req_tag,
  output logic                                in_rsp_valid,
  input  logic                                in_rsp_ready,
  output logic [DATA_WIDTH-1:0]               in_rsp_data,
  output logic [TAG_WIDTH-1:0]                in_rsp_tag,
  output logic [NUM_PORTS-1:0]                mem_req_valid,
  input  logic [NUM_PORTS-1:0]                mem_req_ready,
  output logic [NUM_PORTS-1:0]                mem_req_rw,
  output logic [NUM_PORTS*DATA_WIDTH/8-1:0]   mem_req_byteen,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0]     mem_req_addr,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]     mem_req_data,
  output logic [NUM_PORTS*TAG_WIDTH-1:0]      mem_req_tag,
  input  logic [NUM_PORTS-1:0]                mem_rsp_valid,
  output logic [NUM_PORTS-1:0]                mem_rsp_ready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     mem_rsp_data,
  input  logic [NUM_PORTS*TAG_WIDTH-1:0]      mem_rsp_tag,
  output logic [CTR_WIDTH-1:0]                perf_reads,
  output logic [CTR_WIDTH-1:0]                perf_writes,
  output logic [CTR_WIDTH-1:0]                perf_latency,
  output logic                                busy
);

  localparam int SEL_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int PEND_W = $clog2(MAX_PENDING + 1);

  logic [SEL_W-1:0]            sel;
  logic                        sel_free, sel_room, in_req_fire;
  logic [NUM_PORTS-1:0]        req_valid_q, req_rw_q;
  logic [NUM_PORTS*BE_W-1:0]   req_byteen_q;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr_q;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data_q;
  logic [NUM_PORTS*TAG_WIDTH-1:0]  req_tag_q;
  logic [PEND_W-1:0]           pending_q [NUM_PORTS];
  logic [NUM_PORTS-1:0]        pend_inc, pend_dec;
  logic [SEL_W-1:0]            rr_ptr_q, grant_idx;
  logic                        grant_any, rsp_take;
  int                          arb_idx;
  logic                        rsp_valid_q;
  logic [DATA_WIDTH-1:0]       rsp_data_q;
  logic [TAG_WIDTH-1:0]        rsp_tag_q;
  logic [CTR_WIDTH-1:0]        reads_q, writes_q, latency_q;
  logic [CTR_WIDTH-1:0]        rd_cnt, wr_cnt, pend_sum;
  logic                        pend_any;

  generate
    if (NUM_PORTS > 1) begin : g_sel
      assign sel = in_req_addr[INTERLEAVE_LSB +: SEL_W];
    end else begin : g_sel_single
      assign sel = '0;
    end
  endgenerate

  // The pending limit looks only at the registered count, so a response
  // retiring in the same cycle does not open the gate early.
  always_comb begin
    sel_free = !req_valid_q[sel] || mem_req_ready[sel];
    sel_room = in_req_rw || (pending_q[sel] < PEND_W'(MAX_PENDING));
  end

  assign in_req_ready = sel_free && sel_room;
  assign in_req_fire  = in_req_valid && in_req_ready;

  always_comb begin
    pend_inc = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      pend_inc[i] = in_req_fire && !in_req_rw && (sel == SEL_W'(i));
    end
    pend_dec = mem_rsp_valid & mem_rsp_ready;
  end

  // A register being drained may be refilled in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_valid_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (in_req_fire && (sel == SEL_W'(i))) begin
          req_valid_q[i]                       <= 1'b1;
          req_rw_q[i]                          <= in_req_rw;
          req_byteen_q[i*BE_W +: BE_W]         <= in_req_byteen;
          req_addr_q[i*ADDR_WIDTH +: ADDR_WIDTH] <= in_req_addr;
          req_data_q[i*DATA_WIDTH +: DATA_WIDTH] <= in_req_data;
          req_tag_q[i*TAG_WIDTH +: TAG_WIDTH]    <= in_req_tag;
        end else if (mem_req_ready[i]) begin
          req_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign mem_req_valid  = req_valid_q;
  assign mem_req_rw     = req_rw_q;
  assign mem_req_byteen = req_byteen_q;
  assign mem_req_addr   = req_addr_q;
  assign mem_req_data   = req_data_q;
  assign mem_req_tag    = req_tag_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) pending_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        case ({pend_inc[i], pend_dec[i]})
          2'b10:   pending_q[i] <= pending_q[i] + PEND_W'(1);
          2'b01:   if (pending_q[i] != '0) pending_q[i] <= pending_q[i] - PEND_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Round-robin search starting at rr_ptr; only a channel that can actually
  // hand its response over is told it is ready.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    arb_idx   = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      arb_idx = (int'(rr_ptr_q) + k) % NUM_PORTS;
      if (!grant_any && mem_rsp_valid[arb_idx]) begin
        grant_any = 1'b1;
        grant_idx = SEL_W'(arb_idx);
      end
    end
    rsp_take      = !rsp_valid_q || in_rsp_ready;
    mem_rsp_ready = '0;
    if (grant_any && rsp_take) mem_rsp_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else if (grant_any && rsp_take) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= mem_rsp_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      rsp_tag_q   <= mem_rsp_tag[grant_idx*TAG_WIDTH +: TAG_WIDTH];
      rr_ptr_q    <= (NUM_PORTS == 1) ? '0 : grant_idx + SEL_W'(1);
    end else if (in_rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign in_rsp_valid = rsp_valid_q;
  assign in_rsp_data  = rsp_data_q;
  assign in_rsp_tag   = rsp_tag_q;

  always_comb begin
    rd_cnt   = '0;
    wr_cnt   = '0;
    pend_sum = '0;
    pend_any = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req_valid_q[i] && mem_req_ready[i]) begin
        if (req_rw_q[i]) wr_cnt = wr_cnt + CTR_WIDTH'(1);
        else             rd_cnt = rd_cnt + CTR_WIDTH'(1);
      end
      pend_sum = pend_sum + CTR_WIDTH'(pending_q[i]);
      pend_any = pend_any || (pending_q[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reads_q   <= '0;
      writes_q  <= '0;
      latency_q <= '0;
    end else begin
      reads_q   <= reads_q + rd_cnt;
      writes_q  <= writes_q + wr_cnt;
      latency_q <= latency_q + pend_sum;
    end
  end

  assign perf_reads   = reads_q;
  assign perf_writes  = writes_q;
  assign perf_latency = latency_q;
  assign busy         = (|req_valid_q) || pend_any;

  // A response from a channel with nothing outstanding means the environment
  // lost track of its reads (typically responses left over across a reset).
  generate
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_underflow
      assert property (@(posedge clk) disable iff (reset)
        !(pend_dec[i] && !pend_inc[i] && (pending_q[i] == '0)));
    end
  endgenerate

endmodule

// File: tb/tb_vx_mem_port_splitter.sv
// tb_vx_mem_port_splitter
// Directed scenarios plus a long randomized run, all checked every cycle
// against a transaction-level model of the splitter (per-channel slot,
// integer pending counts, a response slot and plain counters).
module tb_vx_mem_port_splitter;
  localparam int NP = 2, AW = 16, DW = 32, TW = 8, LSB = 0, MP = 4, CW = 44;
  localparam int BE = DW / 8;

  logic clk, reset;
  logic in_req_valid, in_req_ready, in_req_rw;
  logic [BE-1:0] in_req_byteen;
  logic [AW-1:0] in_req_addr;
  logic [DW-1:0] in_req_data;
  logic [TW-1:0] in_req_tag;
  logic in_rsp_valid, in_rsp_ready;
  logic [DW-1:0] in_rsp_data;
  logic [TW-1:0] in_rsp_tag;
  logic [NP-1:0] mem_req_valid, mem_req_ready, mem_req_rw;
  logic [NP*BE-1:0] mem_req_byteen;
  logic [NP*AW-1:0] mem_req_addr;
  logic [NP*DW-1:0] mem_req_data;
  logic [NP*TW-1:0] mem_req_tag;
  logic [NP-1:0] mem_rsp_valid, mem_rsp_ready;
  logic [NP*DW-1:0] mem_rsp_data;
  logic [NP*TW-1:0] mem_rsp_tag;
  logic [CW-1:0] perf_reads, perf_writes, perf_latency;
  logic busy;

  vx_mem_port_splitter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
    .INTERLEAVE_LSB(LSB), .MAX_PENDING(MP), .CTR_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_ready(in_req_ready), .in_req_rw(in_req_rw),
    .in_req_byteen(in_req_byteen), .in_req_addr(in_req_addr), .in_req_data(in_req_data),
    .in_req_tag(in_req_tag),
    .in_rsp_valid(in_rsp_valid), .in_rsp_ready(in_rsp_ready), .in_rsp_data(in_rsp_data),
    .in_rsp_tag(in_rsp_tag),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_tag(mem_req_tag),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag),
    .perf_reads(perf_reads), .perf_writes(perf_writes), .perf_latency(perf_latency),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          rw;
    logic [BE-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } req_t;

  // reference model state
  bit              m_full [NP];
  req_t            m_req  [NP];
  int              m_pend [NP];
  int              m_rr;
  bit              m_out_full;
  logic [DW-1:0]   m_out_data;
  logic [TW-1:0]   m_out_tag;
  longint unsigned m_reads, m_writes, m_lat;
  bit              exp_ready, exp_take;
  int              exp_grant;

  int checks, errors;
  logic [CW-1:0] lat0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int p = 0; p < NP; p++) begin
      m_full[p] = 1'b0;
      m_pend[p] = 0;
    end
    m_rr = 0;
    m_out_full = 1'b0;
    m_reads = 0;
    m_writes = 0;
    m_lat = 0;
  endfunction

  task automatic model_check();
    int ch, idx;
    bit any;
    logic [63:0] exp_mrr;
    ch = int'((in_req_addr >> LSB) % NP);
    exp_ready = (!m_full[ch] || mem_req_ready[ch]) && (in_req_rw || m_pend[ch] < MP);
    exp_grant = -1;
    for (int k = 0; k < NP; k++) begin
      idx = (m_rr + k) % NP;
      if (exp_grant < 0 && mem_rsp_valid[idx]) exp_grant = idx;
    end
    exp_take = !m_out_full || in_rsp_ready;
    exp_mrr = '0;
    if (exp_grant >= 0 && exp_take) exp_mrr[exp_grant] = 1'b1;
    checkOutput("in_req_ready", in_req_ready, exp_ready);
    checkOutput("mem_rsp_ready", mem_rsp_ready, exp_mrr);
    any = 1'b0;
    for (int p = 0; p < NP; p++) begin
      checkOutput("mem_req_valid", mem_req_valid[p], m_full[p]);
      if (m_full[p]) begin
        checkOutput("mem_req_rw", mem_req_rw[p], m_req[p].rw);
        checkOutput("mem_req_addr", mem_req_addr[p*AW +: AW], m_req[p].addr);
        checkOutput("mem_req_data", mem_req_data[p*DW +: DW], m_req[p].data);
        checkOutput("mem_req_tag", mem_req_tag[p*TW +: TW], m_req[p].tag);
        checkOutput("mem_req_byteen", mem_req_byteen[p*BE +: BE], m_req[p].be);
      end
      if (m_full[p] || m_pend[p] > 0) any = 1'b1;
    end
    checkOutput("in_rsp_valid", in_rsp_valid, m_out_full);
    if (m_out_full) begin
      checkOutput("in_rsp_data", in_rsp_data, m_out_data);
      checkOutput("in_rsp_tag", in_rsp_tag, m_out_tag);
    end
    checkOutput("busy", busy, any);
    checkOutput("perf_reads", perf_reads, m_reads[CW-1:0]);
    checkOutput("perf_writes", perf_writes, m_writes[CW-1:0]);
    checkOutput("perf_latency", perf_latency, m_lat[CW-1:0]);
  endtask

  function automatic void model_update();
    int ch;
    if (reset) begin
      model_reset();
      return;
    end
    for (int p = 0; p < NP; p++) m_lat += longint'(m_pend[p]);
    for (int p = 0; p < NP; p++) begin
      if (m_full[p] && mem_req_ready[p]) begin
        if (m_req[p].rw) m_writes++;
        else             m_reads++;
        m_full[p] = 1'b0;
      end
    end
    if (in_req_valid && exp_ready) begin
      ch = int'((in_req_addr >> LSB) % NP);
      m_full[ch]      = 1'b1;
      m_req[ch].rw    = in_req_rw;
      m_req[ch].be    = in_req_byteen;
      m_req[ch].addr  = in_req_addr;
      m_req[ch].data  = in_req_data;
      m_req[ch].tag   = in_req_tag;
      if (!in_req_rw) m_pend[ch]++;
    end
    if (m_out_full && in_rsp_ready) m_out_full = 1'b0;
    if (exp_grant >= 0 && exp_take) begin
      m_out_full = 1'b1;
      m_out_data = mem_rsp_data[exp_grant*DW +: DW];
      m_out_tag  = mem_rsp_tag[exp_grant*TW +: TW];
      m_pend[exp_grant]--;
      m_rr = (exp_grant + 1) % NP;
    end
  endfunction

  // One clock: check outputs mid-cycle, advance the model, land just after the edge.
  task automatic step();
    @(negedge clk);
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_req_valid = 1'b0; in_req_rw = 1'b0; in_req_byteen = '0; in_req_addr = '0;
    in_req_data = '0; in_req_tag = '0; in_rsp_ready = 1'b0;
    mem_req_ready = '0; mem_rsp_valid = '0; mem_rsp_data = '0; mem_rsp_tag = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic send(input bit rw, input logic [AW-1:0] addr, input logic [TW-1:0] tag);
    in_req_valid  = 1'b1;
    in_req_rw     = rw;
    in_req_addr   = addr;
    in_req_tag    = tag;
    in_req_data   = DW'($urandom);
    in_req_byteen = BE'($urandom);
    step();
    in_req_valid  = 1'b0;
  endtask

  task automatic applyStimulus(input int rst_permille);
    in_req_valid  = ($urandom_range(0, 99) < 60);
    in_req_rw     = ($urandom_range(0, 99) < 30);
    in_req_addr   = AW'($urandom);
    in_req_data   = DW'($urandom);
    in_req_byteen = BE'($urandom);
    in_req_tag    = TW'($urandom);
    for (int p = 0; p < NP; p++) begin
      mem_req_ready[p] = ($urandom_range(0, 3) != 0);
      mem_rsp_valid[p] = ($urandom_range(0, 1) == 1) && (m_pend[p] > 0);
    end
    mem_rsp_data = {$urandom, $urandom};
    mem_rsp_tag  = NP*TW'($urandom);
    in_rsp_ready = ($urandom_range(0, 3) != 0);
    reset        = ($urandom_range(0, 999) < rst_permille);
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    reset = 1'b1;
    model_reset();
    step();
    reset = 1'b0;
    checkOutput("rst_mem_req_valid", mem_req_valid, '0);
    checkOutput("rst_in_rsp_valid", in_rsp_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_perf_reads", perf_reads, 0);
    checkOutput("rst_in_req_ready", in_req_ready, 1);

    // address interleave: 0x10 -> port 0, 0x11 -> port 1, 0x12 -> port 0
    mem_req_ready = 2'b11;
    send(1'b0, 16'h10, 8'h21);
    checkOutput("il_valid_a", mem_req_valid, 2'b01);
    checkOutput("il_tag_a", mem_req_tag[7:0], 8'h21);
    send(1'b0, 16'h11, 8'h22);
    checkOutput("il_valid_b", mem_req_valid, 2'b10);
    checkOutput("il_tag_b", mem_req_tag[15:8], 8'h22);
    send(1'b0, 16'h12, 8'h23);
    checkOutput("il_valid_c", mem_req_valid, 2'b01);
    checkOutput("il_tag_c", mem_req_tag[7:0], 8'h23);
    lat0 = perf_latency;
    step();
    checkOutput("il_pending_sum", perf_latency - lat0, 3);
    checkOutput("il_perf_reads", perf_reads, 3);

    // pending limit on port 0
    do_reset();
    mem_req_ready = 2'b11;
    for (int i = 0; i < 4; i++) send(1'b0, 16'(32 + 2 * i), 8'(i));
    in_req_valid = 1'b1; in_req_rw = 1'b0; in_req_addr = 16'h28; in_req_tag = 8'h30;
    #1 checkOutput("lim_read_blocked", in_req_ready, 0);
    in_req_rw = 1'b1;
    #1 checkOutput("lim_write_ok", in_req_ready, 1);
    step();
    in_req_rw = 1'b0; mem_rsp_valid = 2'b01; mem_rsp_tag = 16'h00AA; in_rsp_ready = 1'b1;
    #1 checkOutput("lim_same_cycle", in_req_ready, 0);
    step();
    mem_rsp_valid = 2'b00;
    #1 checkOutput("lim_released", in_req_ready, 1);
    step();
    in_req_valid = 1'b0;
    step();

    // round-robin merge, then a stalled output register
    do_reset();
    mem_req_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 16'(2 * i), 8'(i));
      send(1'b0, 16'(2 * i + 1), 8'(i + 8));
    end
    mem_rsp_valid = 2'b11; mem_rsp_tag = {8'h0B, 8'h0A};
    mem_rsp_data = {$urandom, $urandom}; in_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("rr_tag", in_rsp_tag, (i % 2 == 0) ? 8'h0A : 8'h0B);
    end
    in_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("stall_mem_rsp_ready", mem_rsp_ready, 2'b00);
      step();
      checkOutput("stall_tag", in_rsp_tag, 8'h0B);
    end
    in_rsp_ready = 1'b1;
    step();
    checkOutput("drain_next_tag", in_rsp_tag, 8'h0A);
    mem_rsp_valid = 2'b10;
    step();
    checkOutput("drain_last_tag", in_rsp_tag, 8'h0B);
    mem_rsp_valid = 2'b00;
    step();
    checkOutput("drain_empty", in_rsp_valid, 0);

    // head-of-line blocking behind a stalled port 1
    do_reset();
    mem_req_ready = 2'b01;
    send(1'b1, 16'h31, 8'h40);
    in_req_valid = 1'b1; in_req_rw = 1'b1; in_req_addr = 16'h33; in_req_tag = 8'h41;
    for (int i = 0; i < 10; i++) begin
      #1 checkOutput("hol_stall", in_req_ready, 0);
      step();
    end
    mem_req_ready = 2'b11;
    step();
    checkOutput("hol_perf_writes", perf_writes, 1);
    in_req_rw = 1'b0; in_req_addr = 16'h30; in_req_tag = 8'h55;
    step();
    in_req_valid = 1'b0;
    checkOutput("hol_port0_valid", mem_req_valid[0], 1);
    checkOutput("hol_port0_tag", mem_req_tag[7:0], 8'h55);

    // latency accumulation, then reset in the middle of traffic
    do_reset();
    mem_req_ready = 2'b11;
    send(1'b0, 16'h40, 8'h01);
    send(1'b0, 16'h42, 8'h02);
    step();
    lat0 = perf_latency;
    repeat (5) step();
    checkOutput("lat_delta", perf_latency - lat0, 10);
    checkOutput("lat_reads", perf_reads, 2);
    mem_req_ready = 2'b00;
    send(1'b0, 16'h44, 8'h03);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("mid_rst_mem_req_valid", mem_req_valid, '0);
    checkOutput("mid_rst_in_rsp_valid", in_rsp_valid, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_perf_reads", perf_reads, 0);
    checkOutput("mid_rst_perf_latency", perf_latency, 0);
    checkOutput("mid_rst_in_req_ready", in_req_ready, 1);

    // randomized traffic with one forced reset part-way through
    do_reset();
    for (int i = 0; i < 3000; i++) applyStimulus((i == 1500) ? 1000 : 2);
    clear_inputs();
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
